// File: rtl/univ_shift_reg.sv
// ---------------------------------------------------------------------------
// univ_shift_reg
//   Universal shift register with a built-in serialise burst engine.
//
//   In IDLE, the register is driven by a 3-bit mode select (hold, shift
//   right/left, parallel load, rotate right/left, clear). A start request
//   loads pin and runs a WIDTH-cycle burst. During the burst, sout_r presents
//   pin[0] .. pin[WIDTH-1], one bit per enabled cycle. done pulses for one
//   cycle when the burst completes.
//
//   Optional feature macro: USR_ROTATE_EN
//     defined   : modes 100/101 rotate right/left.
//     undefined : modes 100/101 hold q, and no rotate logic is built.
//
// Parameters
//   WIDTH     : register width, legal range 2..64.
//   RESET_VAL : value loaded into q on reset and on the clear mode.
//
// Ports
//   clk     in   clock; all state changes on the rising edge.
//   rst     in   synchronous active-high reset; overrides everything else.
//   en      in   clock enable; when low, q, state and cnt are frozen.
//   mode    in   [2:0] operation select, used only while idle.
//   pin     in   [WIDTH-1:0] parallel data in.
//   sin_r   in   serial in for right shift; enters at q[WIDTH-1].
//   sin_l   in   serial in for left shift; enters at q[0].
//   start   in   begin a serialise burst (idle only).
//   q       out  [WIDTH-1:0] register contents.
//   sout_r  out  q[0].
//   sout_l  out  q[WIDTH-1].
//   busy    out  high while a burst is in progress.
//   done    out  one-cycle pulse after the final burst cycle.
// ---------------------------------------------------------------------------
module univ_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] pin,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic             start,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [2:0] M_HOLD  = 3'b000;
    localparam logic [2:0] M_SHR   = 3'b001;
    localparam logic [2:0] M_SHL   = 3'b010;
    localparam logic [2:0] M_LOAD  = 3'b011;
    localparam logic [2:0] M_ROR   = 3'b100;
    localparam logic [2:0] M_ROL   = 3'b101;
    localparam logic [2:0] M_CLR   = 3'b110;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] q_q,     q_d;
    logic             done_q,  done_d;

    // -----------------------------------------------------------------------
    // Idle-mode datapath: the value q would take under the current mode.
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] mode_nxt;

    always_comb begin
        mode_nxt = q_q;
        case (mode)
            M_HOLD: mode_nxt = q_q;
            M_SHR:  mode_nxt = {sin_r, q_q[WIDTH-1:1]};
            M_SHL:  mode_nxt = {q_q[WIDTH-2:0], sin_l};
            M_LOAD: mode_nxt = pin;
`ifdef USR_ROTATE_EN
            M_ROR:  mode_nxt = {q_q[0], q_q[WIDTH-1:1]};
            M_ROL:  mode_nxt = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
`endif
            M_CLR:  mode_nxt = RESET_VAL;
            // 111, plus 100/101 when rotation is not built, hold q.
            default: mode_nxt = q_q;
        endcase
    end

    // -----------------------------------------------------------------------
    // Next-state logic.
    // done_d defaults to 0 and is not gated by en, so a done pulse always
    // lasts exactly one clock, even when en drops right after the burst.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        done_d  = 1'b0;

        if (en) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        // start wins over mode: capture the burst word.
                        q_d     = pin;
                        cnt_d   = '0;
                        state_d = SHIFT;
                    end else begin
                        q_d = mode_nxt;
                    end
                end
                SHIFT: begin
                    if (cnt_q != CNT_LAST) begin
                        q_d   = {sin_r, q_q[WIDTH-1:1]};
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        // The last bit has been presented for its cycle.
                        // Hold q and return to idle.
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // State registers. Reset is synchronous and overrides en.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q     <= RESET_VAL;
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            q_q     <= q_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign q      = q_q;
    assign sout_r = q_q[0];
    assign sout_l = q_q[WIDTH-1];
    assign busy   = (state_q == SHIFT);
    assign done   = done_q;

endmodule
